// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Keeps the fetch PC, issues one word
// read at a time to instruction memory over a req/ack handshake, buffers the
// returned words in a small FIFO and feeds decode through registered
// insn/pc/valid_insn outputs. Honours decode stall and execute redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h8002_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        valid_insn
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      buf_insn_q [BUF_DEPTH];
    logic [31:0]      buf_insn_d [BUF_DEPTH];
    logic [31:0]      buf_pc_q   [BUF_DEPTH];
    logic [31:0]      buf_pc_d   [BUF_DEPTH];
    logic             imem_req_q, imem_req_d;
    logic [31:0]      imem_addr_q, imem_addr_d;
    logic [31:0]      insn_q, insn_d;
    logic [31:0]      pc_q, pc_d;
    logic             valid_q, valid_d;

    logic             ack_s;
    logic             push_s;
    logic             pop_s;
    logic             has_room_s;
    logic [31:0]      redir_target_s;

    // Circular-buffer pointer advance that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1'b1);
        end
    endfunction

    // Handshake and FIFO strobes; an ack only counts while a request is up.
    always_comb begin
        ack_s          = imem_ack & imem_req_q;
        redir_target_s = redirect_pc & ~32'd3;
        push_s         = (!redirect) && (state_q == FETCH) && ack_s;
        pop_s          = (!redirect) && (!stall) && (count_q != {CNT_W{1'b0}});
    end

    // Instruction buffer: push at the tail, pop at the head, flush on redirect.
    always_comb begin
        buf_insn_d = buf_insn_q;
        buf_pc_d   = buf_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                buf_insn_d[wr_ptr_q] = imem_data;
                buf_pc_d[wr_ptr_q]   = fetch_pc_q;
                wr_ptr_d             = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
        has_room_s = (count_d < DEPTH_C);
    end

    // Fetch sequencing; the request outputs are derived from the next state
    // so they are registered and stable for the whole outstanding request.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        if (redirect) begin
            target_d = redir_target_s;
            case (state_q)
                FETCH: begin
                    // No request in flight (ack this cycle, or the idle cycle
                    // right after reset): restart directly at the target.
                    if (ack_s || !imem_req_q) begin
                        state_d    = FETCH;
                        fetch_pc_d = redir_target_s;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                FULL: begin
                    state_d    = FETCH;
                    fetch_pc_d = redir_target_s;
                end
                DRAIN: begin
                    // The discarded ack closes the drain even if a newer
                    // redirect arrives in the same cycle; otherwise keep waiting.
                    if (ack_s) begin
                        state_d    = FETCH;
                        fetch_pc_d = redir_target_s;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d    = FETCH;
                    fetch_pc_d = redir_target_s;
                end
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (ack_s) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = has_room_s ? FETCH : FULL;
                    end else begin
                        state_d = FETCH;
                    end
                end
                FULL: begin
                    if (has_room_s) begin
                        state_d = FETCH;
                    end else begin
                        state_d = FULL;
                    end
                end
                DRAIN: begin
                    if (ack_s) begin
                        state_d    = FETCH;
                        fetch_pc_d = target_q;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
        imem_req_d  = (state_d != FULL);
        imem_addr_d = fetch_pc_d;
    end

    // Decode-facing output stage: flush on redirect, hold on stall, else pop.
    always_comb begin
        insn_d  = insn_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (redirect) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (pop_s) begin
            insn_d  = buf_insn_q[rd_ptr_q];
            pc_d    = buf_pc_q[rd_ptr_q];
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // All state and registered outputs, asynchronously cleared by rst_b.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            target_q    <= RESET_PC;
            count_q     <= {CNT_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            buf_insn_q  <= '{default: 32'd0};
            buf_pc_q    <= '{default: 32'd0};
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            insn_q      <= 32'd0;
            pc_q        <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            target_q    <= target_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_insn_q  <= buf_insn_d;
            buf_pc_q    <= buf_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            insn_q      <= insn_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign insn       = insn_q;
    assign pc         = pc_q;
    assign valid_insn = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic for fetch_unit.
// A behavioural memory answers requests with a chosen latency; a scoreboard
// tracks the expected PC stream (start address, then +4 per delivered word).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        valid_insn;

    int checks   = 0;
    int failures = 0;

    // memory model state
    bit          mem_en;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          mem_poison;
    bit          rand_lat;
    int          lat_cfg;

    // scoreboard state
    logic [31:0] exp_pc;
    int          idle_cnt;
    logic        p_stall, p_redir, p_req, p_ack, p_valid, p_rst;
    logic [31:0] p_redir_pc, p_addr, p_pc, p_insn;

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_b(rst_b),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .insn(insn), .pc(pc), .valid_insn(valid_insn)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8002_0000: mem_word = 32'h2402_0001;
            32'h8002_0004: mem_word = 32'h2403_0002;
            32'h8002_0008: mem_word = 32'h0043_1021;
            default:       mem_word = (a * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    // One clock: capture pre-edge values, scoreboard after the edge, then memory reply.
    task automatic tick();
        p_stall = stall; p_redir = redirect; p_redir_pc = redirect_pc;
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
        p_valid = valid_insn; p_pc = pc; p_insn = insn; p_rst = rst_b;
        @(posedge clk);
        #1;
        if (rst_b !== 1'b1 || p_rst !== 1'b1) begin
            exp_pc = RESET_PC;
            idle_cnt = 0;
        end else begin
            checks++;
            if (p_redir) begin
                if (valid_insn !== 1'b0) begin
                    failures++;
                    $display("FAIL flush: valid_insn=%b expected 0", valid_insn);
                end
                exp_pc = p_redir_pc & ~32'd3;
            end else if (p_stall) begin
                if (valid_insn !== p_valid || pc !== p_pc || insn !== p_insn) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b pc=%h insn=%h expected v=%b pc=%h insn=%h",
                             valid_insn, pc, insn, p_valid, p_pc, p_insn);
                end
            end else if (valid_insn === 1'b1) begin
                if (pc !== exp_pc || insn !== mem_word(exp_pc)) begin
                    failures++;
                    $display("FAIL stream: got pc=%h insn=%h expected pc=%h insn=%h",
                             pc, insn, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end else begin
                if (pc !== p_pc || insn !== p_insn) begin
                    failures++;
                    $display("FAIL empty_hold: got pc=%h insn=%h expected pc=%h insn=%h",
                             pc, insn, p_pc, p_insn);
                end
            end
            if (p_req === 1'b1 && p_ack !== 1'b1) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    failures++;
                    $display("FAIL handshake: got req=%b addr=%h expected req=1 addr=%h",
                             imem_req, imem_addr, p_addr);
                end
            end
            checks++;
            if (imem_addr[1:0] !== 2'b00) begin
                failures++;
                $display("FAIL align: addr=%h expected low bits 00", imem_addr);
            end
            if (valid_insn === 1'b1 || p_stall) idle_cnt = 0;
            else idle_cnt++;
            checks++;
            if (idle_cnt > 30) begin
                failures++;
                $display("FAIL watchdog: %0d idle cycles expected <= 30", idle_cnt);
                idle_cnt = 0;
            end
        end
        if (mem_en) begin
            if (p_ack && p_req) mem_busy = 0;
            imem_ack  = 1'b0;
            imem_data = $urandom;
            if (rst_b === 1'b1) begin
                if (!mem_busy && imem_req === 1'b1) begin
                    mem_busy   = 1;
                    mem_cnt    = rand_lat ? int'($urandom_range(1, 3)) : lat_cfg;
                    mem_addr   = imem_addr;
                    mem_poison = 0;
                end
                if (mem_busy) begin
                    mem_cnt--;
                    if (mem_cnt <= 0) begin
                        imem_ack  = 1'b1;
                        imem_data = mem_poison ? 32'hDEAD_BEEF : mem_word(mem_addr);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (imem_req !== 1'b0 || imem_addr !== RESET_PC || insn !== 32'd0 ||
                pc !== 32'd0 || valid_insn !== 1'b0) begin
                failures++;
                $display("FAIL reset_values: req=%b addr=%h insn=%h pc=%h v=%b expected 0/%h/0/0/0",
                         imem_req, imem_addr, insn, pc, valid_insn, RESET_PC);
            end
        end
        rst_b = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || valid_insn !== 1'b0) begin
            failures++;
            $display("FAIL first_req: req=%b addr=%h v=%b expected 1/%h/0", imem_req, imem_addr, valid_insn, RESET_PC);
        end
        // earliest ack lands on the second edge; the word reaches decode one edge later
        tick();
        checks++;
        if (valid_insn !== 1'b0) begin
            failures++;
            $display("FAIL early_valid: v=%b expected 0", valid_insn);
        end
        tick();
        checks++;
        if (valid_insn !== 1'b1 || pc !== RESET_PC || insn !== 32'h2402_0001) begin
            failures++;
            $display("FAIL first_valid: v=%b pc=%h insn=%h expected 1/%h/24020001", valid_insn, pc, insn, RESET_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_insn [2];
        exp_insn[0] = 32'h2403_0002;
        exp_insn[1] = 32'h0043_1021;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (valid_insn !== 1'b1 || pc !== RESET_PC + 32'(4 * (i + 1)) || insn !== exp_insn[i]) begin
                failures++;
                $display("FAIL stream_%0d: v=%b pc=%h insn=%h expected 1/%h/%h",
                         i, valid_insn, pc, insn, RESET_PC + 32'(4 * (i + 1)), exp_insn[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] frozen;
        frozen = pc;
        stall = 1'b1;
        repeat (5) tick();
        checks++;
        if (imem_req !== 1'b0 || valid_insn !== 1'b1 || pc !== frozen) begin
            failures++;
            $display("FAIL stall_full: req=%b v=%b pc=%h expected 0/1/%h", imem_req, valid_insn, pc, frozen);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (valid_insn !== 1'b1 || pc !== frozen + 32'd4) begin
            failures++;
            $display("FAIL stall_release: v=%b pc=%h expected 1/%h", valid_insn, pc, frozen + 32'd4);
        end
    endtask

    task automatic test_redirect_drain();
        logic [31:0] old_addr;
        bit found, acked, ack_now, seen;
        lat_cfg = 3;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (mem_busy && imem_ack === 1'b0 && imem_req === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL drain_setup: no pending request found expected one");
        end
        old_addr = imem_addr;
        redirect = 1'b1; redirect_pc = 32'h8002_0103;
        mem_poison = 1;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== old_addr || valid_insn !== 1'b0) begin
            failures++;
            $display("FAIL drain_hold: req=%b addr=%h v=%b expected 1/%h/0", imem_req, imem_addr, valid_insn, old_addr);
        end
        acked = 0;
        for (int i = 0; i < 10 && !acked; i++) begin
            ack_now = imem_ack;
            tick();
            if (ack_now) acked = 1;
        end
        checks++;
        if (!acked || imem_req !== 1'b1 || imem_addr !== 32'h8002_0100) begin
            failures++;
            $display("FAIL drain_refetch: acked=%b req=%b addr=%h expected 1/1/80020100", acked, imem_req, imem_addr);
        end
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            checks++;
            if (insn === 32'hDEAD_BEEF) begin
                failures++;
                $display("FAIL drain_leak: insn=%h expected never deadbeef", insn);
            end
            if (valid_insn === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || pc !== 32'h8002_0100) begin
            failures++;
            $display("FAIL drain_first: seen=%b pc=%h expected 1/80020100", seen, pc);
        end
    endtask

    task automatic test_simultaneous();
        bit found, seen;
        lat_cfg = 1;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (imem_ack === 1'b1 && imem_req === 1'b1) found = 1;
        end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h8002_0040;
        tick();
        stall = 1'b0; redirect = 1'b0;
        checks++;
        if (!found || valid_insn !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8002_0040) begin
            failures++;
            $display("FAIL simul: found=%b v=%b req=%b addr=%h expected 1/0/1/80020040", found, valid_insn, imem_req, imem_addr);
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (valid_insn === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || pc !== 32'h8002_0040) begin
            failures++;
            $display("FAIL simul_first: seen=%b pc=%h expected 1/80020040", seen, pc);
        end
    endtask

    task automatic test_reset_drain();
        bit found, seen;
        lat_cfg = 3;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (mem_busy && imem_ack === 1'b0 && imem_req === 1'b1) found = 1;
        end
        redirect = 1'b1; redirect_pc = 32'h8002_0200;
        tick();
        redirect = 1'b0;
        rst_b = 1'b0;
        #1;
        checks++;
        if (!found || imem_req !== 1'b0 || imem_addr !== RESET_PC || insn !== 32'd0 ||
            pc !== 32'd0 || valid_insn !== 1'b0) begin
            failures++;
            $display("FAIL rst_drain: found=%b req=%b addr=%h insn=%h pc=%h v=%b expected 1/0/%h/0/0/0",
                     found, imem_req, imem_addr, insn, pc, valid_insn, RESET_PC);
        end
        mem_en = 0; mem_busy = 0;
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        repeat (2) tick();
        rst_b = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || valid_insn !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart: req=%b addr=%h v=%b expected 1/%h/0", imem_req, imem_addr, valid_insn, RESET_PC);
        end
        imem_ack = 1'b0; mem_en = 1; lat_cfg = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (valid_insn === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || pc !== RESET_PC || insn !== 32'h2402_0001) begin
            failures++;
            $display("FAIL rst_first: seen=%b pc=%h insn=%h expected 1/%h/24020001", seen, pc, insn, RESET_PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got [$];
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 20 && got.size() < 3; i++) begin
            tick();
            if (valid_insn === 1'b1) got.push_back(pc);
        end
        checks++;
        if (got.size() != 3 || got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap: got %0d pcs expected fffffff8,fffffffc,00000000", got.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        rand_lat = 1;
        for (int i = 0; i < 500; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 24) == 0);
            r = $urandom;
            redirect_pc = {16'h8002, r[15:0]};
            tick();
        end
        stall = 1'b0; redirect = 1'b0; rand_lat = 0;
        repeat (10) tick();
    endtask

    initial begin
        rst_b = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_data = 32'd0;
        mem_en = 1; mem_busy = 0; mem_cnt = 0; mem_addr = 32'd0; mem_poison = 0;
        rand_lat = 0; lat_cfg = 1; exp_pc = RESET_PC; idle_cnt = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_simultaneous();
        test_reset_drain();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
